// File: rtl/key_decoder_if.sv
// Signal bundle between the keypad encoder side and the key decoder back end.
// The slave modport is the decoder's view; the master modport is the driver's view.
interface key_decoder_if;
  logic [3:0]  L;
  logic        GS;
  logic        clr;
  logic        key_valid;
  logic        err;
  logic [3:0]  key_code;
  logic [9:0]  Y_n;
  logic [15:0] digits;
  logic [1:0]  state;

  modport slave (
    input  L,
    input  GS,
    input  clr,
    output key_valid,
    output err,
    output key_code,
    output Y_n,
    output digits,
    output state
  );

  modport master (
    output L,
    output GS,
    output clr,
    input  key_valid,
    input  err,
    input  key_code,
    input  Y_n,
    input  digits,
    input  state
  );
endinterface

// File: rtl/key_decoder.sv
// Debounces keypad press/release, pulses key_valid/err on each accepted press,
// and keeps the one-hot lamp decode and a 4-digit BCD entry register.
module key_decoder #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  key_decoder_if.slave  kif
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    PRESSED    = 2'd2,
    DB_RELEASE = 2'd3
  } state_e;

  localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_CYC);

  state_e      state_q,     state_d;
  logic [3:0]  cand_q,      cand_d;
  logic [7:0]  cnt_q,       cnt_d;
  logic        key_valid_q, key_valid_d;
  logic        err_q,       err_d;
  logic [3:0]  key_code_q,  key_code_d;
  logic [9:0]  y_n_q,       y_n_d;
  logic [15:0] digits_q,    digits_d;
  logic [7:0]  cnt_inc;

  assign cnt_inc = cnt_q + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cand_q      <= 4'd0;
      cnt_q       <= 8'd0;
      key_valid_q <= 1'b0;
      err_q       <= 1'b0;
      key_code_q  <= 4'd0;
      y_n_q       <= 10'h3FF;
      digits_q    <= 16'h0000;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_valid_q <= key_valid_d;
      err_q       <= err_d;
      key_code_q  <= key_code_d;
      y_n_q       <= y_n_d;
      digits_q    <= digits_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_valid_d = 1'b0;
    err_d       = 1'b0;
    key_code_d  = key_code_q;
    y_n_d       = y_n_q;
    digits_d    = digits_q;

    // Clear lands first so a coinciding accept builds on the cleared entry state.
    if (kif.clr) begin
      key_code_d = 4'd0;
      y_n_d      = 10'h3FF;
      digits_d   = 16'h0000;
    end

    unique case (state_q)
      IDLE: begin
        if (kif.GS) begin
          cand_d  = kif.L;
          cnt_d   = 8'd1;
          state_d = DB_PRESS;
        end
      end

      DB_PRESS: begin
        if (!kif.GS) begin
          state_d = IDLE;
        end else if (kif.L != cand_q) begin
          cand_d = kif.L;
          cnt_d  = 8'd1;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == DB_LIMIT) begin
            state_d = PRESSED;
            if (cand_q <= 4'd9) begin
              key_valid_d = 1'b1;
              key_code_d  = cand_q;
              y_n_d       = ~(10'd1 << cand_q);
              digits_d    = {digits_d[11:0], cand_q};
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end

      PRESSED: begin
        // Code changes while held are ignored: a roll gives nothing until release.
        if (!kif.GS) begin
          cnt_d   = 8'd1;
          state_d = DB_RELEASE;
        end
      end

      DB_RELEASE: begin
        if (kif.GS) begin
          state_d = PRESSED;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == DB_LIMIT) begin
            state_d = IDLE;
            y_n_d   = 10'h3FF;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign kif.key_valid = key_valid_q;
  assign kif.err       = err_q;
  assign kif.key_code  = key_code_q;
  assign kif.Y_n       = y_n_q;
  assign kif.digits    = digits_q;
  assign kif.state     = state_q;

endmodule

// File: tb/tb_key_decoder.sv
// Directed bench for key_decoder with DEBOUNCE_CYC=4: press/release timing,
// bounce, key roll, entry register, invalid code, clear and mid-press reset.
module tb_key_decoder;

  logic clk;
  logic rst_n;

  key_decoder_if kif();

  key_decoder #(.DEBOUNCE_CYC(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int kv_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  // Pulse monitors: read pre-edge values, so a pulse is counted one edge after it rises.
  always @(posedge clk) begin
    if (kif.key_valid) kv_cnt++;
    if (kif.err) err_cnt++;
    if (kif.key_valid && kif.err) both_cnt++;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_release(input logic [3:0] code);
    kif.GS = 1'b1;
    kif.L  = code;
    step(5);
    kif.GS = 1'b0;
    step(5);
  endtask

  initial begin
    rst_n   = 1'b0;
    kif.GS  = 1'b0;
    kif.L   = 4'd0;
    kif.clr = 1'b0;
    step(2);

    check("rst_key_valid", 16'(kif.key_valid), 16'h0);
    check("rst_err",       16'(kif.err),       16'h0);
    check("rst_key_code",  16'(kif.key_code),  16'h0);
    check("rst_y_n",       16'(kif.Y_n),       16'h03FF);
    check("rst_digits",    kif.digits,         16'h0000);
    rst_n = 1'b1;
    step(1);

    // Clean press of key 7: accept on the 4th sampling edge.
    kv_cnt = 0;
    kif.GS = 1'b1;
    kif.L  = 4'd7;
    step(1); check("p7_kv_e0", 16'(kif.key_valid), 16'h0);
    step(1); check("p7_kv_e1", 16'(kif.key_valid), 16'h0);
    step(1); check("p7_kv_e2", 16'(kif.key_valid), 16'h0);
    check("p7_y_n_pre", 16'(kif.Y_n), 16'h03FF);
    step(1); check("p7_kv_e3", 16'(kif.key_valid), 16'h1);
    check("p7_key_code", 16'(kif.key_code), 16'h7);
    check("p7_y_n",      16'(kif.Y_n),      16'h037F);
    check("p7_digits",   kif.digits,        16'h0007);
    step(1); check("p7_kv_e4", 16'(kif.key_valid), 16'h0);
    step(5);
    kif.GS = 1'b0;
    step(3); check("r7_y_n_r2", 16'(kif.Y_n), 16'h037F);
    step(1); check("r7_y_n_r3", 16'(kif.Y_n), 16'h03FF);
    check("r7_key_code", 16'(kif.key_code), 16'h7);
    check("r7_digits",   kif.digits,        16'h0007);
    step(2);
    check("p7_pulses", 16'(kv_cnt), 16'd1);

    // Clear the entry state.
    kif.clr = 1'b1;
    step(1);
    kif.clr = 1'b0;
    check("clr_digits",   kif.digits,        16'h0000);
    check("clr_key_code", 16'(kif.key_code), 16'h0);

    // Press bounce: GS 1,1,0,1,1,1,1 with L=3.
    kv_cnt = 0;
    kif.L  = 4'd3;
    kif.GS = 1'b1; step(2);
    kif.GS = 1'b0; step(1);
    kif.GS = 1'b1; step(3);
    check("bnc_kv_early", 16'(kif.key_valid), 16'h0);
    step(1);
    check("bnc_kv_4th", 16'(kif.key_valid), 16'h1);
    check("bnc_digits", kif.digits, 16'h0003);
    kif.GS = 1'b0;
    step(5);
    check("bnc_pulses", 16'(kv_cnt), 16'd1);

    // Code change during debounce, then key roll while pressed.
    kv_cnt = 0;
    kif.GS = 1'b1;
    kif.L  = 4'd2; step(2);
    kif.L  = 4'd5; step(3);
    check("roll_kv_pre", 16'(kif.key_valid), 16'h0);
    step(1);
    check("roll_kv",       16'(kif.key_valid), 16'h1);
    check("roll_key_code", 16'(kif.key_code),  16'h5);
    check("roll_digits",   kif.digits,         16'h0035);
    kif.L = 4'd8;
    step(6);
    check("roll_pulses",   16'(kv_cnt),        16'd1);
    check("roll_key_hold", 16'(kif.key_code),  16'h5);
    check("roll_y_n",      16'(kif.Y_n),       16'h03DF);
    kif.GS = 1'b0;
    step(5);
    check("roll_y_n_rel", 16'(kif.Y_n), 16'h03FF);

    // Entry sequence 1,2,3,4,9.
    kv_cnt = 0;
    press_release(4'd1);
    press_release(4'd2);
    press_release(4'd3);
    check("entry_mid", kif.digits, 16'h5123);
    press_release(4'd4);
    press_release(4'd9);
    check("entry_digits",   kif.digits,        16'h2349);
    check("entry_pulses",   16'(kv_cnt),       16'd5);
    check("entry_key_code", 16'(kif.key_code), 16'h9);

    // Invalid code 12.
    kv_cnt  = 0;
    err_cnt = 0;
    kif.GS = 1'b1;
    kif.L  = 4'd12;
    step(4);
    check("inv_err",      16'(kif.err),       16'h1);
    check("inv_kv",       16'(kif.key_valid), 16'h0);
    check("inv_key_code", 16'(kif.key_code),  16'h9);
    check("inv_y_n",      16'(kif.Y_n),       16'h03FF);
    check("inv_digits",   kif.digits,         16'h2349);
    step(1);
    check("inv_err_low", 16'(kif.err), 16'h0);
    kif.GS = 1'b0;
    step(5);
    check("inv_err_pulses", 16'(err_cnt), 16'd1);
    check("inv_kv_pulses",  16'(kv_cnt),  16'd0);

    // Clear coinciding with the accept edge of key 6.
    kif.GS = 1'b1;
    kif.L  = 4'd6;
    step(3);
    kif.clr = 1'b1;
    step(1);
    kif.clr = 1'b0;
    check("clracc_kv",       16'(kif.key_valid), 16'h1);
    check("clracc_digits",   kif.digits,         16'h0006);
    check("clracc_y_n",      16'(kif.Y_n),       16'h03BF);
    check("clracc_key_code", 16'(kif.key_code),  16'h6);
    kif.GS = 1'b0;
    step(5);

    // Reset asserted mid-DB_PRESS with key 4 held.
    kv_cnt = 0;
    kif.GS = 1'b1;
    kif.L  = 4'd4;
    step(2);
    rst_n = 1'b0;
    #1;
    check("mrst_kv",       16'(kif.key_valid), 16'h0);
    check("mrst_key_code", 16'(kif.key_code),  16'h0);
    check("mrst_y_n",      16'(kif.Y_n),       16'h03FF);
    check("mrst_digits",   kif.digits,         16'h0000);
    step(1);
    rst_n = 1'b1;
    step(3);
    check("mrst_kv_early", 16'(kif.key_valid), 16'h0);
    check("mrst_pulses0",  16'(kv_cnt),        16'd0);
    step(1);
    check("mrst_kv_acc", 16'(kif.key_valid), 16'h1);
    check("mrst_digits_acc", kif.digits, 16'h0004);
    kif.GS = 1'b0;
    step(5);
    check("mrst_y_n_rel", 16'(kif.Y_n), 16'h03FF);
    check("never_both",   16'(both_cnt), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
